// File: rtl/demux_pkg.sv
// ============================================================================
// Module   : demux_pkg
// Purpose  : Shared sizes and types for the 1-to-4 stream demultiplexer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_pkg;
    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;
    localparam int CNT_W   = 16;

    typedef logic [SEL_W-1:0] sel_t;
endpackage

`default_nettype wire

// File: rtl/demux_1to4_stream_if.sv
// ============================================================================
// Module   : demux_1to4_stream_if
// Purpose  : Producer/consumer bus of the demux; beat_count exists only when
//            DEMUX_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface demux_1to4_stream_if
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic                              in_valid;
    logic                              in_ready;
    logic [WIDTH-1:0]                  in_data;
    sel_t                              in_sel;
    logic [NUM_OUT-1:0]                out_valid;
    logic [NUM_OUT-1:0]                out_ready;
    logic [NUM_OUT-1:0][WIDTH-1:0]     out_data;
    sel_t                              cur_sel;
`ifdef DEMUX_STATS_EN
    logic [NUM_OUT-1:0][CNT_W-1:0]     beat_count;
`endif

    // Demux side of the bus.
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, cur_sel
`ifdef DEMUX_STATS_EN
        , output beat_count
`endif
    );

    // Producer/consumer side of the bus.
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, cur_sel
`ifdef DEMUX_STATS_EN
        , input beat_count
`endif
    );
endinterface

`default_nettype wire

// File: rtl/demux_out_slot.sv
// ============================================================================
// Module   : demux_out_slot
// Purpose  : One-entry output register slice with same-cycle drain/reload.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_out_slot #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load_i,
    input  wire logic             drain_i,
    input  wire logic [WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [WIDTH-1:0]      data_o
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // A load wins over a drain so a slot reloads in the cycle it empties.
    always_comb begin
        valid_d = load_i | (valid_q & ~drain_i);
        data_d  = load_i ? data_i : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

`default_nettype wire

// File: rtl/demux_1to4_stream.sv
// ============================================================================
// Module   : demux_1to4_stream
// Purpose  : Steers one valid/ready stream into four registered output slots,
//            by per-beat select or round-robin pointer. Optional per-channel
//            beat counters are enabled by the macro DEMUX_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_1to4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int RR_MODE = 0
) (
    input wire logic             clk,
    input wire logic             rst,
    demux_1to4_stream_if.slave   bus
);
    sel_t               ptr_q, ptr_d;
    sel_t               w_tgt;
    logic               w_accept;
    logic [NUM_OUT-1:0] w_load;

    assign w_tgt        = (RR_MODE != 0) ? ptr_q : bus.in_sel;
    assign bus.cur_sel  = w_tgt;
    assign bus.in_ready = ~bus.out_valid[w_tgt] | bus.out_ready[w_tgt];
    assign w_accept     = bus.in_valid & bus.in_ready;

    // The pointer only moves on an accepted beat, so a blocked channel stalls it.
    always_comb begin
        ptr_d = ptr_q;
        if (w_accept) begin
            ptr_d = ptr_q + sel_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    generate
        for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
            assign w_load[k] = w_accept & (w_tgt == sel_t'(k));

            demux_out_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk     (clk),
                .rst     (rst),
                .load_i  (w_load[k]),
                .drain_i (bus.out_ready[k]),
                .data_i  (bus.in_data),
                .valid_o (bus.out_valid[k]),
                .data_o  (bus.out_data[k])
            );
        end
    endgenerate

`ifdef DEMUX_STATS_EN
    generate
        for (genvar k = 0; k < NUM_OUT; k++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (w_load[k] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign bus.beat_count[k] = cnt_q;
        end
    endgenerate
`endif
endmodule

`default_nettype wire

// File: tb/tb_demux_1to4_stream.sv
// ============================================================================
// Module   : tb_demux_1to4_stream
// Purpose  : Directed self-checking bench for select mode and round-robin mode;
//            counter checks are included when DEMUX_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_1to4_stream;
    import demux_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    demux_1to4_stream_if #(.WIDTH(8)) bus0 ();
    demux_1to4_stream_if #(.WIDTH(8)) bus1 ();

    demux_1to4_stream #(.WIDTH(8), .RR_MODE(0)) u_dut_sel (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    demux_1to4_stream #(.WIDTH(8), .RR_MODE(1)) u_dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ch;
        n_checks = 0;
        n_fail   = 0;
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_sel = '0; bus0.out_ready = 4'hF;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_sel = '0; bus1.out_ready = 4'hF;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        check("rst_valid0",  32'(bus0.out_valid), 32'h0);
        check("rst_data0",   32'(bus0.out_data),  32'h0);
        check("rst_ready0",  32'(bus0.in_ready),  32'h1);
        check("rst_cursel1", 32'(bus1.cur_sel),   32'h0);

        // Basic routing to channel 2.
        bus0.in_sel = 2'd2; bus0.in_data = 8'hA5; bus0.in_valid = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        check("basic_valid",  32'(bus0.out_valid),   32'h4);
        check("basic_data2",  32'(bus0.out_data[2]), 32'hA5);
        step();
        check("basic_drain",  32'(bus0.out_valid),   32'h0);

        // Backpressure on channel 1.
        bus0.out_ready = 4'b1101;
        bus0.in_sel = 2'd1; bus0.in_data = 8'h10; bus0.in_valid = 1'b1;
        step();
        bus0.in_data = 8'h20;
        check("bp_ready_low", 32'(bus0.in_ready),    32'h0);
        check("bp_hold10",    32'(bus0.out_data[1]), 32'h10);
        step();
        check("bp_still10",   32'(bus0.out_data[1]), 32'h10);
        check("bp_valid",     32'(bus0.out_valid),   32'h2);
        check("bp_other",     32'(bus0.out_data[2]), 32'hA5);
        bus0.out_ready = 4'hF;
        #1;
        check("bp_ready_up",  32'(bus0.in_ready),    32'h1);
        step();
        bus0.in_valid = 1'b0;
        check("bp_data20",    32'(bus0.out_data[1]), 32'h20);
        check("bp_valid20",   32'(bus0.out_valid),   32'h2);
        step();
        check("bp_empty",     32'(bus0.out_valid),   32'h0);

        // Back-to-back beats on channel 0.
        bus0.in_sel = 2'd0; bus0.in_data = 8'h11; bus0.in_valid = 1'b1;
        step();
        check("b2b_ready1", 32'(bus0.in_ready),    32'h1);
        check("b2b_d11",    32'(bus0.out_data[0]), 32'h11);
        check("b2b_v1",     32'(bus0.out_valid),   32'h1);
        bus0.in_data = 8'h22;
        step();
        check("b2b_ready2", 32'(bus0.in_ready),    32'h1);
        check("b2b_d22",    32'(bus0.out_data[0]), 32'h22);
        check("b2b_v2",     32'(bus0.out_valid),   32'h1);
        bus0.in_data = 8'h33;
        step();
        bus0.in_valid = 1'b0;
        check("b2b_d33",    32'(bus0.out_data[0]), 32'h33);
        check("b2b_v3",     32'(bus0.out_valid),   32'h1);
        step();
        check("b2b_done",   32'(bus0.out_valid),   32'h0);

        // Round-robin: five beats land on channels 0,1,2,3,0.
        for (int i = 1; i <= 5; i++) begin
            ch = (i - 1) % 4;
            bus1.in_data = 8'(i); bus1.in_valid = 1'b1;
            #1;
            check($sformatf("rr_sel%0d", i), 32'(bus1.cur_sel), 32'(ch));
            step();
            check($sformatf("rr_valid%0d", i), 32'(bus1.out_valid),    32'(1 << ch));
            check($sformatf("rr_data%0d", i),  32'(bus1.out_data[ch]), 32'(i));
        end
        bus1.in_valid = 1'b0;
        check("rr_wrap", 32'(bus1.cur_sel), 32'h1);

        // Round-robin with consumer 2 stalled: beat 7 blocks at channel 2.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus1.out_ready = 4'b1011;
        for (int i = 1; i <= 6; i++) begin
            ch = (i - 1) % 4;
            bus1.in_data = 8'(i); bus1.in_valid = 1'b1;
            #1;
            check($sformatf("rrs_sel%0d", i), 32'(bus1.cur_sel), 32'(ch));
            step();
            check($sformatf("rrs_data%0d", i), 32'(bus1.out_data[ch]), 32'(i));
        end
        bus1.in_data = 8'h07;
        #1;
        check("rrs_blocked", 32'(bus1.in_ready), 32'h0);
        step();
        step();
        check("rrs_ptr_held", 32'(bus1.cur_sel),     32'h2);
        check("rrs_slot2",    32'(bus1.out_data[2]), 32'h03);
        check("rrs_valid2",   32'(bus1.out_valid[2]), 32'h1);
        bus1.out_ready = 4'hF;
        #1;
        check("rrs_unblock", 32'(bus1.in_ready), 32'h1);
        step();
        bus1.in_valid = 1'b0;
        check("rrs_data7",   32'(bus1.out_data[2]), 32'h07);
        check("rrs_advance", 32'(bus1.cur_sel),     32'h3);

        // Reset mid-operation with every slot of the select DUT full.
        step();
        bus0.out_ready = 4'h0;
        bus1.out_ready = 4'h0;
        for (int i = 0; i < 4; i++) begin
            bus0.in_sel = 2'(i); bus0.in_data = 8'(8'hC0 + i); bus0.in_valid = 1'b1;
            step();
        end
        bus0.in_valid = 1'b0;
        check("full_valid", 32'(bus0.out_valid), 32'hF);
        check("full_ready", 32'(bus0.in_ready),  32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid0", 32'(bus0.out_valid), 32'h0);
        check("mid_rst_data0",  32'(bus0.out_data),  32'h0);
        check("mid_rst_ready0", 32'(bus0.in_ready),  32'h1);
        check("mid_rst_valid1", 32'(bus1.out_valid), 32'h0);
        check("mid_rst_ptr1",   32'(bus1.cur_sel),   32'h0);
        bus0.out_ready = 4'hF;
        bus1.out_ready = 4'hF;

`ifdef DEMUX_STATS_EN
        check("cnt_rst", 32'(bus0.beat_count), 32'h0);
        bus0.in_sel = 2'd3; bus0.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus0.in_data = 8'(i);
            step();
        end
        bus0.in_valid = 1'b0;
        check("cnt3",  32'(bus0.beat_count[3]), 32'd3);
        check("cnt0",  32'(bus0.beat_count[0]), 32'd0);
        check("cnt1",  32'(bus0.beat_count[1]), 32'd0);
        check("cnt2",  32'(bus0.beat_count[2]), 32'd0);
        bus0.in_sel = 2'd0; bus0.in_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            step();
        end
        bus0.in_valid = 1'b0;
        check("cnt_full", 32'(bus0.beat_count[0]), 32'hFFFF);
        bus0.in_valid = 1'b1;
        step();
        step();
        bus0.in_valid = 1'b0;
        check("cnt_sat",  32'(bus0.beat_count[0]), 32'hFFFF);
        check("cnt3_keep", 32'(bus0.beat_count[3]), 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
